// File: rtl/memstage_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : memstage_pkg                                                 |
// | Purpose  : Shared types and constants for the bexkat1 memory stage:      |
// |            instruction type codes, access-size and FSM state enums.      |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
package memstage_pkg;

   // Instruction type lives in ir[31:28]; access size in ir[25:24].
   localparam logic [3:0] T_LOAD  = 4'h7;
   localparam logic [3:0] T_STORE = 4'h8;

   typedef enum logic [1:0] {
      MS_WORD = 2'b00,
      MS_HALF = 2'b01,
      MS_BYTE = 2'b10
   } memsize_t;

   typedef enum logic [0:0] {
      MS_IDLE = 1'b0,
      MS_BUS  = 1'b1
   } memstate_t;

   // The reserved size code 2'b11 behaves as a word access.
   function automatic memsize_t decode_size(input logic [1:0] f);
      case (f)
         2'b01:   return MS_HALF;
         2'b10:   return MS_BYTE;
         default: return MS_WORD;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/memstage_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : memstage_if                                                  |
// | Purpose  : 32-bit big-endian master bus between the memory stage and   |
// |            the memory system. cyc/stb/we/sel/adr/dat_w map to the        |
// |            bus_*_o signals, dat_r/ack to bus_dat_i/bus_ack_i.            |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
interface memstage_if #(
   parameter int AW = 32
);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [3:0]    sel;
   logic [AW-1:0] adr;
   logic [31:0]   dat_w;
   logic [31:0]   dat_r;
   logic          ack;

   modport master (
      output cyc, stb, we, sel, adr, dat_w,
      input  dat_r, ack
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w,
      output dat_r, ack
   );
endinterface
`default_nettype wire

// File: rtl/memstage_bus_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : memstage_bus_lane                                            |
// | Purpose  : Combinational big-endian lane logic: byte-select generation, |
// |            store-data replication and zero-extended load extraction.    |
// |            Lane [3] / bits [31:24] hold the lowest byte address.        |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module memstage_bus_lane
   import memstage_pkg::*;
(
   input  memsize_t    i_size,
   input  logic [1:0]  i_adr,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   // Decode lanes, replicate write data and pick read data by size/offset.
   always_comb begin
      o_sel   = 4'b1111;
      o_wdata = i_wdata;
      o_rdata = i_rdata;
      case (i_size)
         MS_HALF: begin
            o_sel   = i_adr[1] ? 4'b0011 : 4'b1100;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {16'h0000, (i_adr[1] ? i_rdata[15:0] : i_rdata[31:16])};
         end
         MS_BYTE: begin
            o_sel   = 4'b1000 >> i_adr;
            o_wdata = {4{i_wdata[7:0]}};
            case (i_adr)
               2'd0:    o_rdata = {24'h000000, i_rdata[31:24]};
               2'd1:    o_rdata = {24'h000000, i_rdata[23:16]};
               2'd2:    o_rdata = {24'h000000, i_rdata[15:8]};
               default: o_rdata = {24'h000000, i_rdata[7:0]};
            endcase
         end
         default: begin
            o_sel   = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/memstage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : memstage                                                     |
// | Purpose  : bexkat1 memory-access pipeline stage. Loads and stores run a |
// |            bus cycle and stall the pipe until ack; every other          |
// |            instruction passes through one register stage.               |
// | Config   : MEMSTAGE_ALIGN_TRAP_EN - misaligned word/half accesses raise |
// |            exc_o instead of being address-masked.                       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module memstage
   import memstage_pkg::*;
#(
   parameter int AW = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [63:0] ir_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] result_i,
   input  logic [31:0] reg_data1_i,
   input  logic [1:0]  reg_write_i,
   input  logic [2:0]  ccr_i,
   output logic        stall_o,
   output logic [63:0] ir_o,
   output logic [31:0] pc_o,
   output logic [31:0] result_o,
   output logic [1:0]  reg_write_o,
   output logic [2:0]  ccr_o,
   output logic        exc_o,
   memstage_if.master  bus
);

   logic [3:0]    w_type;
   logic          w_is_load;
   logic          w_is_store;
   logic          w_is_mem;
   logic          w_trap;
   logic          w_start;
   memsize_t      w_size;
   logic [1:0]    w_lo;
   logic [AW-1:0] w_adr;
   logic [3:0]    w_sel;
   logic [31:0]   w_wdata;
   logic [31:0]   w_rdata;

   memstate_t     r_state;
   memstate_t     w_next;
   logic          w_stall;

   logic          r_cyc;
   logic          r_we;
   logic [3:0]    r_sel;
   logic [AW-1:0] r_adr;
   logic [31:0]   r_dat;

   logic [63:0]   r_ir;
   logic [31:0]   r_pc;
   logic [31:0]   r_result;
   logic [1:0]    r_reg_write;
   logic [2:0]    r_ccr;

   assign w_type     = ir_i[31:28];
   assign w_is_load  = (w_type == T_LOAD);
   assign w_is_store = (w_type == T_STORE);
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_size     = decode_size(ir_i[25:24]);

   // Force the low address bits to the natural alignment of the access size.
   always_comb begin
      w_lo = result_i[1:0];
      case (w_size)
         MS_WORD: w_lo = 2'b00;
         MS_HALF: w_lo = {result_i[1], 1'b0};
         default: w_lo = result_i[1:0];
      endcase
      w_adr = {result_i[AW-1:2], w_lo};
   end

`ifdef MEMSTAGE_ALIGN_TRAP_EN
   assign w_trap = w_is_mem &
                   (((w_size == MS_WORD) && (result_i[1:0] != 2'b00)) ||
                    ((w_size == MS_HALF) && result_i[0]));
`else
   assign w_trap = 1'b0;
`endif

   assign w_start = w_is_mem & ~w_trap;

   // Inputs are held stable while stalled, so one lane decoder serves both
   // the bus-cycle launch and the load-data extraction at ack.
   memstage_bus_lane u_lane (
      .i_size  (w_size),
      .i_adr   (w_lo),
      .i_wdata (reg_data1_i),
      .i_rdata (bus.dat_r),
      .o_sel   (w_sel),
      .o_wdata (w_wdata),
      .o_rdata (w_rdata)
   );

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= MS_IDLE;
      else       r_state <= w_next;
   end

   // Next-state and stall; stall drops in the ack cycle so upstream advances.
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      case (r_state)
         MS_IDLE: begin
            if (w_start) begin
               w_next  = MS_BUS;
               w_stall = 1'b1;
            end
         end
         MS_BUS: begin
            if (bus.ack) w_next  = MS_IDLE;
            else         w_stall = 1'b1;
         end
         default: w_next = MS_IDLE;
      endcase
   end

   // Bus master registers: launched from IDLE, held until ack.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cyc <= 1'b0;
         r_we  <= 1'b0;
         r_sel <= 4'h0;
         r_adr <= '0;
         r_dat <= 32'h0;
      end else begin
         case (r_state)
            MS_IDLE: begin
               if (w_start) begin
                  r_cyc <= 1'b1;
                  r_we  <= w_is_store;
                  r_sel <= w_sel;
                  r_adr <= w_adr;
                  r_dat <= w_wdata;
               end
            end
            MS_BUS: begin
               if (bus.ack) begin
                  r_cyc <= 1'b0;
                  r_we  <= 1'b0;
                  r_sel <= 4'h0;
                  r_adr <= '0;
                  r_dat <= 32'h0;
               end
            end
            default: r_cyc <= 1'b0;
         endcase
      end
   end

   // Writeback-facing pipeline register: pass-through, bubble while stalled,
   // or the completed memory op on the ack edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ir        <= 64'h0;
         r_pc        <= 32'h0;
         r_result    <= 32'h0;
         r_reg_write <= 2'b00;
         r_ccr       <= 3'b000;
      end else begin
         case (r_state)
            MS_IDLE: begin
               if (w_start) begin
                  r_ir        <= 64'h0;
                  r_reg_write <= 2'b00;
               end else begin
                  r_ir        <= ir_i;
                  r_pc        <= pc_i;
                  r_result    <= result_i;
                  r_reg_write <= w_is_mem ? 2'b00 : reg_write_i;
                  r_ccr       <= ccr_i;
               end
            end
            MS_BUS: begin
               if (bus.ack) begin
                  r_ir        <= ir_i;
                  r_pc        <= pc_i;
                  r_ccr       <= ccr_i;
                  r_result    <= w_is_load ? w_rdata : result_i;
                  r_reg_write <= w_is_load ? 2'b11 : 2'b00;
               end else begin
                  r_ir        <= 64'h0;
                  r_reg_write <= 2'b00;
               end
            end
            default: begin
               r_ir        <= 64'h0;
               r_reg_write <= 2'b00;
            end
         endcase
      end
   end

`ifdef MEMSTAGE_ALIGN_TRAP_EN
   logic r_exc;

   // One-cycle exception flag for a misaligned access accepted in IDLE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_exc <= 1'b0;
      else       r_exc <= (r_state == MS_IDLE) & w_trap;
   end

   assign exc_o = r_exc;
`else
   assign exc_o = 1'b0;
`endif

   assign stall_o     = w_stall;
   assign ir_o        = r_ir;
   assign pc_o        = r_pc;
   assign result_o    = r_result;
   assign reg_write_o = r_reg_write;
   assign ccr_o       = r_ccr;

   assign bus.cyc     = r_cyc;
   assign bus.stb     = r_cyc;
   assign bus.we      = r_we;
   assign bus.sel     = r_sel;
   assign bus.adr     = r_adr;
   assign bus.dat_w   = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_memstage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_memstage                                                  |
// | Purpose  : Self-checking bench for memstage with a transaction-level    |
// |            reference model. Honours MEMSTAGE_ALIGN_TRAP_EN.             |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module tb_memstage;

   localparam logic [3:0] TL = 4'h7;
   localparam logic [3:0] TS = 4'h8;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [63:0] ir_i;
   logic [31:0] pc_i, result_i, reg_data1_i;
   logic [1:0]  reg_write_i;
   logic [2:0]  ccr_i;
   logic        stall_o;
   logic [63:0] ir_o;
   logic [31:0] pc_o, result_o;
   logic [1:0]  reg_write_o;
   logic [2:0]  ccr_o;
   logic        exc_o;

   memstage_if #(.AW(32)) u_bus ();

   memstage #(.AW(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .ir_i        (ir_i),
      .pc_i        (pc_i),
      .result_i    (result_i),
      .reg_data1_i (reg_data1_i),
      .reg_write_i (reg_write_i),
      .ccr_i       (ccr_i),
      .stall_o     (stall_o),
      .ir_o        (ir_o),
      .pc_o        (pc_o),
      .result_o    (result_o),
      .reg_write_o (reg_write_o),
      .ccr_o       (ccr_o),
      .exc_o       (exc_o),
      .bus         (u_bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // expected outputs maintained by the model
   logic        chk_en = 1'b0;
   logic        exp_stall, exp_cyc, exp_we, exp_chk_dat, exp_exc;
   logic [3:0]  exp_sel;
   logic [31:0] exp_adr, exp_dat, exp_pc, exp_res;
   logic [63:0] exp_ir;
   logic [1:0]  exp_rw;
   logic [2:0]  exp_ccr;

   // observations for the literal checks
   logic        seen_cyc, seen_we;
   logic [3:0]  seen_sel;
   logic [31:0] seen_adr, seen_dat;
   int          stall_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model helpers ----------------
   function automatic int m_nb(input logic [1:0] f);
      return (f == 2'b01) ? 2 : (f == 2'b10) ? 1 : 4;
   endfunction

   function automatic logic [31:0] m_mask(input int nb);
      return (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
   endfunction

   // offset of the first byte, after natural alignment
   function automatic int m_off(input int nb, input logic [31:0] a);
      int o;
      o = int'(a % 32'd4);
      return o - (o % nb);
   endfunction

   function automatic logic [3:0] m_sel(input int nb, input int off);
      logic [3:0] s;
      s = 4'h0;
      for (int i = 0; i < nb; i++) s[3 - (off + i)] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_rep(input int nb, input logic [31:0] d);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < 4 / nb; k++) r = (r << (8 * nb)) | (d & m_mask(nb));
      return r;
   endfunction

   function automatic logic [31:0] m_ext(input int nb, input int off, input logic [31:0] rd);
      return (rd >> (8 * (4 - off - nb))) & m_mask(nb);
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", 64'(stall_o), 64'(exp_stall));
         chk("ir", ir_o, exp_ir);
         chk("pc", 64'(pc_o), 64'(exp_pc));
         chk("result", 64'(result_o), 64'(exp_res));
         chk("reg_write", 64'(reg_write_o), 64'(exp_rw));
         chk("ccr", 64'(ccr_o), 64'(exp_ccr));
         chk("exc", 64'(exc_o), 64'(exp_exc));
         chk("cyc", 64'(u_bus.cyc), 64'(exp_cyc));
         chk("stb", 64'(u_bus.stb), 64'(exp_cyc));
         if (exp_cyc) begin
            chk("we", 64'(u_bus.we), 64'(exp_we));
            chk("sel", 64'(u_bus.sel), 64'(exp_sel));
            chk("adr", 64'(u_bus.adr), 64'(exp_adr));
            if (exp_chk_dat) chk("dat_o", 64'(u_bus.dat_w), 64'(exp_dat));
         end
      end
   end

   // ---------------- stimulus tasks (start at posedge+1) ----------------
   task automatic do_alu(input logic [63:0] ir, input logic [31:0] pc, input logic [31:0] res,
                         input logic [1:0] rw, input logic [2:0] ccr, input logic ack);
      ir_i = ir; pc_i = pc; result_i = res; reg_write_i = rw; ccr_i = ccr;
      reg_data1_i = $urandom; u_bus.ack = ack; u_bus.dat_r = $urandom;
      exp_stall = 1'b0;
      @(posedge clk); #1;
      exp_ir = ir; exp_pc = pc; exp_res = res; exp_rw = rw; exp_ccr = ccr; exp_exc = 1'b0;
      u_bus.ack = 1'b0;
   endtask

   task automatic do_mem(input logic is_store, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] pc,
                         input logic [2:0] ccr, input int d);
      logic [63:0] ir;
      int nb, off;
      logic misal, trap;
      ir = {$urandom, $urandom};
      ir[31:28] = is_store ? TS : TL;
      ir[25:24] = sz;
      nb    = m_nb(sz);
      off   = m_off(nb, a);
      misal = (a % nb) != 0;
`ifdef MEMSTAGE_ALIGN_TRAP_EN
      trap = misal;
`else
      trap = 1'b0;
`endif
      ir_i = ir; pc_i = pc; result_i = a; reg_data1_i = wd; reg_write_i = 2'($urandom);
      ccr_i = ccr; u_bus.ack = 1'($urandom); u_bus.dat_r = $urandom;
      stall_seen = 0;
      if (trap) begin
         exp_stall = 1'b0;
         @(posedge clk); #1;
         seen_cyc = u_bus.cyc;
         exp_ir = ir; exp_pc = pc; exp_ccr = ccr; exp_res = a; exp_rw = 2'b00; exp_exc = 1'b1;
         u_bus.ack = 1'b0;
      end else begin
         exp_stall = 1'b1;
         #2; if (stall_o) stall_seen++;
         @(posedge clk); #1;
         seen_cyc = u_bus.cyc; seen_we = u_bus.we; seen_sel = u_bus.sel;
         seen_adr = u_bus.adr; seen_dat = u_bus.dat_w;
         exp_cyc = 1'b1; exp_we = is_store; exp_sel = m_sel(nb, off);
         exp_adr = a - (a % nb); exp_dat = m_rep(nb, wd); exp_chk_dat = is_store;
         exp_ir = 64'h0; exp_rw = 2'b00; exp_exc = 1'b0;
         u_bus.ack = 1'b0;
         for (int k = 0; k < d; k++) begin
            u_bus.dat_r = $urandom;
            #2; if (stall_o) stall_seen++;
            @(posedge clk); #1;
         end
         u_bus.ack = 1'b1; u_bus.dat_r = rd; exp_stall = 1'b0;
         #2; if (stall_o) stall_seen++;
         @(posedge clk); #1;
         u_bus.ack = 1'b0;
         exp_cyc = 1'b0; exp_chk_dat = 1'b0;
         exp_ir = ir; exp_pc = pc; exp_ccr = ccr;
         exp_res = is_store ? a : m_ext(nb, off, rd);
         exp_rw  = is_store ? 2'b00 : 2'b11;
      end
   endtask

   task automatic set_exp_reset();
      exp_stall = 1'b0; exp_cyc = 1'b0; exp_we = 1'b0; exp_chk_dat = 1'b0; exp_exc = 1'b0;
      exp_sel = 4'h0; exp_adr = 32'h0; exp_dat = 32'h0; exp_pc = 32'h0; exp_res = 32'h0;
      exp_ir = 64'h0; exp_rw = 2'b00; exp_ccr = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ir;
      rst_i = 1'b1;
      ir_i = 64'h0; pc_i = 32'h0; result_i = 32'h0; reg_data1_i = 32'h0;
      reg_write_i = 2'b00; ccr_i = 3'b000; u_bus.ack = 1'b0; u_bus.dat_r = 32'h0;
      set_exp_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset ir", ir_o, 64'h0);
      chk("reset result", 64'(result_o), 64'h0);
      chk("reset reg_write", 64'(reg_write_o), 64'h0);
      chk("reset cyc", 64'(u_bus.cyc), 64'h0);
      chk("reset stall", 64'(stall_o), 64'h0);
      rst_i = 1'b0;
      chk_en = 1'b1;

      // 1: ALU pass-through
      ir = 64'h0000_0000_1000_0001;
      do_alu(ir, 32'h40, 32'h1234, 2'b01, 3'b010, 1'b0);
      chk("alu result", 64'(result_o), 64'h1234);
      chk("alu reg_write", 64'(reg_write_o), 64'h1);

      // 2: word load @0x100, stall high three cycles
      do_mem(1'b0, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 32'h44, 3'b001, 2);
      chk("wload sel", 64'(seen_sel), 64'hF);
      chk("wload stall cycles", 64'(stall_seen), 64'd3);
      chk("wload result", 64'(result_o), 64'hDEADBEEF);
      chk("wload reg_write", 64'(reg_write_o), 64'h3);

      // 3: byte store @0x103
      do_mem(1'b1, 2'b10, 32'h103, 32'h0000_00AB, 32'h0, 32'h48, 3'b100, 1);
      chk("bstore we", 64'(seen_we), 64'h1);
      chk("bstore sel", 64'(seen_sel), 64'h1);
      chk("bstore dat", 64'(seen_dat), 64'hABABABAB);
      chk("bstore reg_write", 64'(reg_write_o), 64'h0);

      // 4: half load @0x102
      do_mem(1'b0, 2'b01, 32'h102, 32'h0, 32'h11223344, 32'h4C, 3'b000, 0);
      chk("hload sel", 64'(seen_sel), 64'h3);
      chk("hload result", 64'(result_o), 64'h3344);

      // 5: reset while a bus cycle is outstanding
      ir = 64'h0;
      ir[31:28] = TL;
      ir_i = ir; result_i = 32'h200; u_bus.ack = 1'b0;
      exp_stall = 1'b1;
      @(posedge clk); #1;
      exp_cyc = 1'b1; exp_we = 1'b0; exp_sel = 4'hF; exp_adr = 32'h200;
      exp_ir = 64'h0; exp_rw = 2'b00;
      @(posedge clk); #1;
      chk_en = 1'b0;
      rst_i = 1'b1; ir_i = 64'h0; u_bus.ack = 1'b1;
      #1;
      chk("rst cyc", 64'(u_bus.cyc), 64'h0);
      chk("rst stb", 64'(u_bus.stb), 64'h0);
      chk("rst ir", ir_o, 64'h0);
      chk("rst reg_write", 64'(reg_write_o), 64'h0);
      @(posedge clk); #1;
      rst_i = 1'b0;
      set_exp_reset();
      chk_en = 1'b1;
      do_alu(64'h0, 32'h50, 32'h77, 2'b10, 3'b011, 1'b1);
      chk("late ack cyc", 64'(u_bus.cyc), 64'h0);

      // 6: misaligned word load @0x101
      do_mem(1'b0, 2'b00, 32'h101, 32'h0, 32'hCAFEF00D, 32'h54, 3'b101, 1);
`ifdef MEMSTAGE_ALIGN_TRAP_EN
      chk("trap cyc", 64'(seen_cyc), 64'h0);
      chk("trap exc", 64'(exc_o), 64'h1);
`else
      chk("mask adr", 64'(seen_adr), 64'h100);
      chk("mask exc", 64'(exc_o), 64'h0);
`endif

      // randomized mix
      for (int n = 0; n < 300; n++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         if (kind < 2) begin
            logic [3:0] t;
            ir = {$urandom, $urandom};
            t  = 4'($urandom_range(0, 15));
            if (t == TL || t == TS) t = 4'h0;
            ir[31:28] = t;
            do_alu(ir, $urandom, $urandom, 2'($urandom), 3'($urandom), 1'($urandom));
         end else begin
            do_mem(kind == 3, 2'($urandom), $urandom, $urandom, $urandom, $urandom,
                   3'($urandom), int'($urandom_range(0, 3)));
         end
      end

      do_alu(64'h0, 32'h0, 32'h0, 2'b00, 3'b000, 1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
